// File: rtl/recip_pkg.sv
// Shared definitions for the reciprocal normalisation controller.
// Holds the controller state encoding, the out_flags bit positions and the
// fixed-point constants for the default Q7.11 format (WORD_LENGTH=18,
// FRAC_LENGTH=11).
package recip_pkg;

    localparam int unsigned DEF_WORD_LENGTH = 18;
    localparam int unsigned DEF_FRAC_LENGTH = 11;

    // Fixed-point landmarks of the default format.
    localparam int unsigned ONE_FP  = 32'd1 << DEF_FRAC_LENGTH;
    localparam int unsigned HALF_FP = ONE_FP >> 1;
    localparam int unsigned MAX_POS = (32'd1 << (DEF_WORD_LENGTH - 1)) - 32'd1;

    // out_flags layout: {timeout, saturated, div_zero}.
    localparam int unsigned FLAG_DIV_ZERO  = 0;
    localparam int unsigned FLAG_SATURATED = 1;
    localparam int unsigned FLAG_TIMEOUT   = 2;
    localparam int unsigned FLAG_W         = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DENORM = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

endpackage

// File: rtl/recip_denorm.sv
// Combinational denormalisation of the core reciprocal.
// Shifts the core result left by k (k>0) or arithmetically right by -k,
// clamps magnitudes beyond WORD_LENGTH-1 bits to 2^(WORD_LENGTH-1)-1, and
// finally applies the operand sign.
// Ports:
//   i_result  core reciprocal of the normalised magnitude
//   i_k       signed normalisation shift count (two's complement, K_W bits)
//   i_neg     operand was negative
//   o_data_c  signed 1/x
//   o_sat_c   result was clamped
module recip_denorm
    import recip_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int unsigned K_W         = 7
) (
    input  logic [WORD_LENGTH-1:0] i_result,
    input  logic [K_W-1:0]         i_k,
    input  logic                   i_neg,
    output logic [WORD_LENGTH-1:0] o_data_c,
    output logic                   o_sat_c
);

    localparam int unsigned EW = 2 * WORD_LENGTH;

    localparam logic [WORD_LENGTH-1:0] L_MAX_W = {1'b0, {(WORD_LENGTH - 1){1'b1}}};
    localparam logic [WORD_LENGTH-1:0] L_MIN_W = WORD_LENGTH'(~L_MAX_W + 1'b1);
    localparam logic signed [EW-1:0]   L_MAX_E = {{(WORD_LENGTH + 1){1'b0}}, {(WORD_LENGTH - 1){1'b1}}};
    localparam logic signed [EW-1:0]   L_MIN_E = EW'(~L_MAX_E + 1'b1);

    logic signed [EW-1:0]   w_ext;
    logic signed [EW-1:0]   w_shift;
    logic [K_W-1:0]         w_k_abs;
    logic                   w_k_neg;
    logic                   w_big;
    logic [WORD_LENGTH-1:0] w_mag;

    // Shift in a double-width domain so a left shift below WORD_LENGTH
    // can never wrap before the range check.
    always_comb begin : p_shift
        w_ext   = {{WORD_LENGTH{i_result[WORD_LENGTH-1]}}, i_result};
        w_k_neg = i_k[K_W-1];
        w_k_abs = w_k_neg ? K_W'(~i_k + K_W'(1)) : i_k;
        w_big   = 1'b0;
        w_shift = w_ext;
        if (w_k_neg) begin
            w_shift = w_ext >>> w_k_abs;
        end else if (w_k_abs >= K_W'(WORD_LENGTH)) begin
            // Any non-zero value shifted this far is out of range.
            w_big = (i_result != '0);
        end else begin
            w_shift = w_ext <<< w_k_abs;
        end
    end

    // Clamp to the symmetric signed range, then apply the operand sign.
    always_comb begin : p_clamp
        o_sat_c = 1'b0;
        w_mag   = w_shift[WORD_LENGTH-1:0];
        if (w_big) begin
            o_sat_c = 1'b1;
            w_mag   = i_result[WORD_LENGTH-1] ? L_MIN_W : L_MAX_W;
        end else if (w_shift > L_MAX_E) begin
            o_sat_c = 1'b1;
            w_mag   = L_MAX_W;
        end else if (w_shift < L_MIN_E) begin
            o_sat_c = 1'b1;
            w_mag   = L_MIN_W;
        end
        o_data_c = i_neg ? WORD_LENGTH'(~w_mag + 1'b1) : w_mag;
    end

endmodule

// File: rtl/recip_norm_ctrl.sv
// Reciprocal normalisation controller around a CORDIC reciprocal core.
// Accepts a signed operand x, normalises |x| into [0.5,1.0) with one shift
// per cycle, hands it to the core, waits for the core result, denormalises
// and signs it, and presents 1/x with status flags.
// Optional macro RECIP_NORM_TIMEOUT_EN adds a watchdog on the core
// handshake (TIMEOUT_CYCLES cycles in WAIT); without it WAIT is unbounded
// and the timeout flag is always 0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_in_valid/o_in_ready      operand handshake, i_in_data = x
//   o_core_enable              one-cycle start pulse to the core
//   o_core_input               normalised magnitude (held while waiting)
//   i_core_result/i_core_valid core reciprocal and its valid pulse
//   o_out_valid/i_out_ready    result handshake
//   o_out_data                 signed 1/x
//   o_out_flags                {timeout, saturated, div_zero}
module recip_norm_ctrl
    import recip_pkg::*;
#(
    parameter int unsigned WORD_LENGTH    = DEF_WORD_LENGTH,
    parameter int unsigned FRAC_LENGTH    = DEF_FRAC_LENGTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [WORD_LENGTH-1:0] i_in_data,
    output logic                   o_core_enable,
    output logic [WORD_LENGTH-1:0] o_core_input,
    input  logic [WORD_LENGTH-1:0] i_core_result,
    input  logic                   i_core_valid,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WORD_LENGTH-1:0] o_out_data,
    output logic [FLAG_W-1:0]      o_out_flags
);

    // Shift count spans roughly -WORD_LENGTH..+WORD_LENGTH.
    localparam int unsigned K_W = $clog2(WORD_LENGTH) + 2;

    localparam logic [WORD_LENGTH-1:0] L_ONE     = WORD_LENGTH'(1) << FRAC_LENGTH;
    localparam logic [WORD_LENGTH-1:0] L_HALF    = L_ONE >> 1;
    localparam logic [WORD_LENGTH-1:0] L_MAX     = {1'b0, {(WORD_LENGTH - 1){1'b1}}};
    localparam logic [WORD_LENGTH-1:0] L_MOST_NEG = {1'b1, {(WORD_LENGTH - 1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_sign,        w_sign_nxt;
    logic [WORD_LENGTH-1:0] r_mag,         w_mag_nxt;
    logic [K_W-1:0]         r_k,           w_k_nxt;
    logic [WORD_LENGTH-1:0] r_core_input,  w_core_input_nxt;
    logic [WORD_LENGTH-1:0] r_result,      w_result_nxt;
    logic [WORD_LENGTH-1:0] r_out_data,    w_out_data_nxt;
    logic [FLAG_W-1:0]      r_out_flags,   w_out_flags_nxt;
    logic                   r_in_ready,    w_in_ready_nxt;
    logic                   r_core_enable, w_core_enable_nxt;
    logic                   r_out_valid,   w_out_valid_nxt;

    logic [WORD_LENGTH-1:0] w_abs;
    logic [WORD_LENGTH-1:0] w_den_data;
    logic                   w_den_sat;

`ifdef RECIP_NORM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]        r_to_cnt, w_to_cnt_nxt;
    logic                   w_to_expired;

    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // The limit only matters with the watchdog; a zero limit is never sensible.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_limit_unused
    end
`endif

    // Operand magnitude; the most-negative value has no positive twin.
    assign w_abs = (i_in_data == L_MOST_NEG) ? L_MAX :
                   (i_in_data[WORD_LENGTH-1] ? WORD_LENGTH'(~i_in_data + 1'b1) : i_in_data);

    recip_denorm #(
        .WORD_LENGTH (WORD_LENGTH),
        .K_W         (K_W)
    ) u_denorm (
        .i_result (r_result),
        .i_k      (r_k),
        .i_neg    (r_sign),
        .o_data_c (w_den_data),
        .o_sat_c  (w_den_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for every register.
    always_comb begin : p_next
        w_state_nxt      = r_state;
        w_sign_nxt       = r_sign;
        w_mag_nxt        = r_mag;
        w_k_nxt          = r_k;
        w_core_input_nxt = r_core_input;
        w_result_nxt     = r_result;
        w_out_data_nxt   = r_out_data;
        w_out_flags_nxt  = r_out_flags;
`ifdef RECIP_NORM_TIMEOUT_EN
        w_to_cnt_nxt     = '0;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (i_in_valid && r_in_ready) begin
                    w_sign_nxt = i_in_data[WORD_LENGTH-1];
                    w_mag_nxt  = w_abs;
                    w_k_nxt    = '0;
                    if (i_in_data == '0) begin
                        w_state_nxt                    = ST_OUT;
                        w_out_data_nxt                 = L_MAX;
                        w_out_flags_nxt                = '0;
                        w_out_flags_nxt[FLAG_DIV_ZERO] = 1'b1;
                    end else begin
                        w_state_nxt = ST_NORM;
                    end
                end
            end

            ST_NORM: begin
                if (r_mag < L_HALF) begin
                    w_mag_nxt = r_mag << 1;
                    w_k_nxt   = r_k + K_W'(1);
                end else if (r_mag >= L_ONE) begin
                    w_mag_nxt = r_mag >> 1;
                    w_k_nxt   = r_k - K_W'(1);
                end else begin
                    w_state_nxt      = ST_ISSUE;
                    w_core_input_nxt = r_mag;
                end
            end

            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_core_valid) begin
                    w_result_nxt = i_core_result;
                    w_state_nxt  = ST_DENORM;
`ifdef RECIP_NORM_TIMEOUT_EN
                end else if (w_to_expired) begin
                    w_state_nxt                   = ST_OUT;
                    w_out_data_nxt                = '0;
                    w_out_flags_nxt               = '0;
                    w_out_flags_nxt[FLAG_TIMEOUT] = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
`endif
                end
            end

            ST_DENORM: begin
                w_state_nxt                     = ST_OUT;
                w_out_data_nxt                  = w_den_data;
                w_out_flags_nxt                 = '0;
                w_out_flags_nxt[FLAG_SATURATED] = w_den_sat;
            end

            ST_OUT: begin
                if (r_out_valid && i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        w_in_ready_nxt    = (w_state_nxt == ST_IDLE);
        w_core_enable_nxt = (w_state_nxt == ST_ISSUE);
        w_out_valid_nxt   = (w_state_nxt == ST_OUT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_mag         <= '0;
            r_k           <= '0;
            r_core_input  <= '0;
            r_result      <= '0;
            r_out_data    <= '0;
            r_out_flags   <= '0;
            r_in_ready    <= 1'b1;
            r_core_enable <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            r_sign        <= w_sign_nxt;
            r_mag         <= w_mag_nxt;
            r_k           <= w_k_nxt;
            r_core_input  <= w_core_input_nxt;
            r_result      <= w_result_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_flags   <= w_out_flags_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_core_enable <= w_core_enable_nxt;
            r_out_valid   <= w_out_valid_nxt;
        end
    end

`ifdef RECIP_NORM_TIMEOUT_EN
    // Watchdog counter; only advances while waiting on the core.
    always_ff @(posedge clk or negedge rst_n) begin : p_timeout
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign o_in_ready    = r_in_ready;
    assign o_core_enable = r_core_enable;
    assign o_core_input  = r_core_input;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_flags   = r_out_flags;

endmodule

// File: tb/tb_recip_norm_ctrl.sv
// Bench for recip_norm_ctrl: directed and random operands against an
// arithmetic 1/x reference, with a behavioural 12-cycle reciprocal core.
module tb_recip_norm_ctrl;
    import recip_pkg::*;

    localparam int WL       = 18;
    localparam int FL       = 11;
    localparam int CORE_LAT = 12;
    localparam int TO_LIM   = 64;
    localparam int TOL      = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [WL-1:0] i_in_data = '0;
    logic          o_core_enable;
    logic [WL-1:0] o_core_input;
    logic [WL-1:0] core_result = '0;
    logic          core_valid = 1'b0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic [WL-1:0] o_out_data;
    logic [2:0]    o_out_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    recip_norm_ctrl #(
        .WORD_LENGTH    (WL),
        .FRAC_LENGTH    (FL),
        .TIMEOUT_CYCLES (TO_LIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .o_core_enable (o_core_enable),
        .o_core_input  (o_core_input),
        .i_core_result (core_result),
        .i_core_valid  (core_valid),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_out_flags   (o_out_flags)
    );

    // Reference reciprocal in Q7.11: round(2^22 / m).
    function automatic logic [WL-1:0] ref_recip(input logic [WL-1:0] m);
        longint num;
        if (m == '0) return WL'(MAX_POS);
        num = (longint'(1) << (2 * FL)) + longint'(m) / 2;
        return WL'(num / longint'(m));
    endfunction

    // Behavioural core: result appears CORE_LAT cycles after the enable cycle.
    bit            core_never = 1'b0;
    bit            core_pend = 1'b0;
    bit            core_abort = 1'b0;
    int            core_cnt = 0;
    logic [WL-1:0] core_res_q = '0;
    logic [WL-1:0] core_in_q = '0;
    logic [WL-1:0] last_core_input = '0;
    int            en_cycles = 0;
    bit            en_long = 1'b0;
    logic          en_prev = 1'b0;
    bit            hold_bad = 1'b0;

    always @(posedge clk) begin
        core_valid <= 1'b0;
        en_prev    <= o_core_enable;
        if (o_core_enable) begin
            en_cycles <= en_cycles + 1;
            if (en_prev) en_long <= 1'b1;
        end
        if (!rst_n) core_abort <= 1'b1;
        if (core_pend) begin
            if (!core_abort && rst_n && (o_core_input !== core_in_q)) hold_bad <= 1'b1;
            if (core_cnt <= 1) begin
                core_valid  <= 1'b1;
                core_result <= core_res_q;
                core_pend   <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        if (o_core_enable && !core_never) begin
            core_pend       <= 1'b1;
            core_cnt        <= CORE_LAT - 1;
            core_in_q       <= o_core_input;
            core_res_q      <= ref_recip(o_core_input);
            last_core_input <= o_core_input;
            core_abort      <= 1'b0;
        end
    end

    // Expected signed 1/x in Q7.11 and flags {timeout, saturated, div_zero}.
    function automatic void ref_out(input int x, output int d, output int f);
        longint ax, r;
        if (x == 0) begin
            d = int'(MAX_POS);
            f = 1;
            return;
        end
        ax = (x < 0) ? -longint'(x) : longint'(x);
        r  = ((longint'(1) << (2 * FL)) + ax / 2) / ax;
        f  = 0;
        if (r > longint'(MAX_POS)) begin
            r = longint'(MAX_POS);
            f = 2;
        end
        d = (x < 0) ? -int'(r) : int'(r);
    endfunction

    // Cycles spent normalising: one per shift into [0.5,1.0) plus the in-range cycle.
    function automatic int norm_cycles(input int x);
        int ax, s;
        ax = (x < 0) ? -x : x;
        if (ax > int'(MAX_POS)) ax = int'(MAX_POS);
        s = 0;
        while (ax < int'(HALF_FP)) begin ax = ax * 2; s++; end
        while (ax >= int'(ONE_FP)) begin ax = ax / 2; s++; end
        return s + 1;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert ((obs - exp) <= TOL && (exp - obs) <= TOL) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
        end
    endtask

    // Offer x, wait for the result, hold out_ready low for `hold` cycles, then consume.
    task automatic run_op(input int x, input int hold, output int d, output int f, output int lat);
        int guard;
        guard = 0;
        while (!o_in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = WL'(x);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_reached", longint'(o_out_valid), 1);
        d = int'($signed(o_out_data));
        f = int'(o_out_flags);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_data", longint'($signed(o_out_data)), d);
            chk("hold_flags", longint'(o_out_flags), f);
            chk("hold_in_ready", longint'(o_in_ready), 0);
            chk("hold_out_valid", longint'(o_out_valid), 1);
        end
        @(negedge clk);
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        chk("release_out_valid", longint'(o_out_valid), 0);
        chk("release_in_ready", longint'(o_in_ready), 1);
    endtask

    // Full check of one operand against the reference, including latency.
    task automatic check_op(input int x, input int hold);
        int d, f, lat, ed, ef, elat;
        ref_out(x, ed, ef);
        elat = (x == 0) ? 1 : (1 + norm_cycles(x) + 1 + CORE_LAT + 1);
        run_op(x, hold, d, f, lat);
        if (ef == 0) chk_tol($sformatf("data x=%0d", x), d, ed);
        else         chk($sformatf("data x=%0d", x), d, ed);
        chk($sformatf("flags x=%0d", x), f, ef);
        chk($sformatf("latency x=%0d", x), lat, elat);
    endtask

    initial begin
        int en0, x, nv, nr, d, f, lat;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_enable", longint'(o_core_enable), 0);
        chk("rst_core_input", longint'(o_core_input), 0);
        chk("rst_out_valid", longint'(o_out_valid), 0);
        chk("rst_out_data", longint'(o_out_data), 0);
        chk("rst_out_flags", longint'(o_out_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", longint'(o_in_ready), 1);

        // 2.0 -> two right shifts, core sees 0.5, result 0.5.
        check_op(4096, 0);
        chk("core_input_4096", longint'(last_core_input), 1024);
        // 0.25 -> one left shift, core sees 0.5, result 4.0.
        check_op(512, 0);
        chk("core_input_512", longint'(last_core_input), 1024);
        check_op(-4096, 0);

        // Zero: no core activity, immediate div_zero result.
        en0 = en_cycles;
        check_op(0, 0);
        chk("zero_no_core_enable", en_cycles, en0);

        // Smallest positive operand saturates; result held under back-pressure.
        check_op(1, 5);
        check_op(-1, 2);
        check_op(1024, 0);
        check_op(2048, 1);
        check_op(32, 0);
        check_op(33, 0);
        check_op(-131072, 0);
        check_op(131071, 0);

        // Random operands away from the saturation boundary.
        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(131071, 40));
            if ($urandom_range(1, 0) == 1) x = -x;
            check_op(x, int'($urandom_range(2, 0)));
        end

        chk("core_enable_single_cycle", longint'(en_long), 0);
        chk("core_input_held", longint'(hold_bad), 0);

`ifdef RECIP_NORM_TIMEOUT_EN
        // Core never answers: watchdog ends the wait.
        core_never = 1'b1;
        run_op(4096, 0, d, f, lat);
        chk("timeout_data", d, 0);
        chk("timeout_flags", f, 4);
        chk("timeout_latency", lat, 1 + norm_cycles(4096) + 1 + TO_LIM);
        core_never = 1'b0;
`endif

        // Reset in the middle of WAIT aborts; the late core answer is ignored.
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = WL'(512);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midwait_rst_core_enable", longint'(o_core_enable), 0);
        chk("midwait_rst_core_input", longint'(o_core_input), 0);
        chk("midwait_rst_out_valid", longint'(o_out_valid), 0);
        chk("midwait_rst_out_data", longint'(o_out_data), 0);
        chk("midwait_rst_out_flags", longint'(o_out_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        nr = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (o_out_valid) nv++;
            if (!o_in_ready) nr++;
        end
        chk("late_core_valid_out_valid_cycles", nv, 0);
        chk("late_core_valid_in_ready_low_cycles", nr, 0);

        // Normal operation after the abort.
        check_op(4096, 0);
        check_op(-512, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/recip_norm_ctrl.md
RECIP_NORM_CTRL -- requirements
Module: recip_norm_ctrl

Interface
REQ-001 Parameter WORD_LENGTH, default 18: operand and result width, signed two's complement.
REQ-002 Parameter FRAC_LENGTH, default 11: fractional bits; 1.0 = 2^FRAC_LENGTH.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: watchdog limit for the core handshake (used only with the macro in REQ-026).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  operand offered.
REQ-007 in_ready  out  1  block can accept an operand.
REQ-008 in_data  in  WORD_LENGTH  signed operand x.
REQ-009 core_enable  out  1  one-cycle start pulse to the CORDIC reciprocal core.
REQ-010 core_input  out  WORD_LENGTH  normalized magnitude sent to the core.
REQ-011 core_result  in  WORD_LENGTH  core reciprocal output.
REQ-012 core_valid  in  1  core result-valid pulse.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_data  out  WORD_LENGTH  signed 1/x.
REQ-016 out_flags  out  3  {timeout, saturated, div_zero}.

Function
REQ-017 FSM states: IDLE, NORM, ISSUE, WAIT, DENORM, OUT; in_ready = 1 only in IDLE.
REQ-018 IDLE: when in_valid and in_ready are both 1, the block captures sign and |x| (the most-negative value saturates to max positive). The shift count k is cleared to 0. Next state is NORM, or OUT with div_zero=1 and out_data=2^(WORD_LENGTH-1)-1 when x=0.
REQ-019 NORM: one shift per cycle until the magnitude lies in [0.5,1.0).
  - If below 0.5: shift left, k+1.
  - If at or above 1.0: shift right, k-1.
  - An operand already in range spends exactly one NORM cycle.
REQ-020 ISSUE: core_enable=1 for exactly one cycle, with core_input = normalized magnitude; then go to WAIT.
REQ-021 core_input is held constant from ISSUE until core_valid is sampled; core_enable=0 in every state except ISSUE.
REQ-022 WAIT: on core_valid=1, register core_result and go to DENORM; core_valid in any other state is ignored.
REQ-023 DENORM, one cycle:
  - Compute result = core_result shifted left by k (k>0) or arithmetic right by -k (k<=0).
  - If the magnitude overflows WORD_LENGTH-1 bits, clamp to 2^(WORD_LENGTH-1)-1 and set saturated=1.
  - If the captured sign is negative, negate the result.
REQ-024 OUT: out_valid=1. out_data and out_flags are held stable while out_ready=0. When out_valid and out_ready are both 1, return to IDLE with out_valid=0 in the next cycle; in_ready rises in that same cycle.
REQ-025 Latency from accept to out_valid = 1 + norm cycles + 1 + core latency + 1; a zero operand reaches OUT in 1 cycle.

Configuration
REQ-026 With macro RECIP_NORM_TIMEOUT_EN defined, a counter runs in WAIT. If it reaches TIMEOUT_CYCLES with no core_valid, the FSM goes to OUT with out_data=0 and timeout=1. Without the macro, there is no counter, timeout is tied to 0, and WAIT waits indefinitely.

Reset
REQ-027 While RST=0: state=IDLE; in_ready=1 after release; core_enable=0; core_input=0; out_valid=0; out_data=0; out_flags=0; k=0; the timeout counter=0.
REQ-028 Reset asserted in any state, including mid-WAIT, aborts the operation. A core_valid arriving after release is ignored because the FSM is in IDLE.

Structure
REQ-029 A shared package recip_pkg holds the FSM state enum, the flag bit indices, and constants ONE_FP, HALF_FP and MAX_POS, all derived from WORD_LENGTH/FRAC_LENGTH.
REQ-030 One sub-module, recip_denorm (combinational shift, saturate and negate), is instantiated for the DENORM datapath; the FSM and registers stay in recip_norm_ctrl.

Verification
Defaults Q7.11; 1.0=2048; the bench core model is a reference 1/x with 12-cycle latency; tolerance ±4 LSB after denorm.
REQ-031 x=4096 (2.0) -> two NORM right shifts, core_input=1024, k=-2, out_data~1024 (0.5), flags=000.
REQ-032 x=512 (0.25) -> one left shift, core_input=1024, k=1, out_data~8192 (4.0), flags=000.
REQ-033 x=-4096 -> out_data~-1024; x=0 -> no core_enable pulse, out_data=131071, div_zero=1, out_valid exactly 1 cycle after accept.
REQ-034 x=1 (2^-11) -> result exceeds range, out_data=131071, saturated=1; with out_ready held 0 for 5 cycles, out_data and out_flags stay constant and in_ready stays 0.
REQ-035 With the macro defined, the core model never asserts core_valid -> after 64 WAIT cycles out_valid=1, out_data=0, timeout=1. Reset pulsed mid-WAIT -> all outputs at reset values; a late core_valid produces no out_valid.
